// File: rtl/stream_demux_1to4_pkg.sv
// Shared constants and the 2-to-4 destination decode for the 1-to-4 stream router.
package stream_demux_1to4_pkg;

   localparam int NUM_CH     = 4;
   localparam int DEST_W     = 2;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_CNT_W  = 8;

   // One-hot channel enable for a destination index.
   function automatic logic [NUM_CH-1:0] dest_onehot(input logic [DEST_W-1:0] dest);
      logic [NUM_CH-1:0] oh;
      oh       = '0;
      oh[dest] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/stream_demux_1to4_if.sv
// Input stream plus four output streams of the 1-to-4 router.
interface stream_demux_1to4_if
   import stream_demux_1to4_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) ();

   logic [DATA_W-1:0]        in_data;
   logic [DEST_W-1:0]        in_dest;
   logic                     in_valid;
   logic                     in_ready;
   logic [NUM_CH*DATA_W-1:0] out_data;
   logic [NUM_CH-1:0]        out_valid;
   logic [NUM_CH-1:0]        out_ready;

   // Source and consumers side.
   modport master (
      output in_data, in_dest, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   // Router side.
   modport slave (
      input  in_data, in_dest, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );

endinterface

// File: rtl/demux_channel_reg.sv
// One output channel: single-entry holding register, valid flag and a
// saturating delivery counter.
module demux_channel_reg #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              ready,
   input  logic              cnt_clr,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic [CNT_W-1:0]  cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic drain;

   assign drain = valid & ready;

   // Holding register: a load wins over a drain so back-to-back words stream at full rate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         data  <= load_data;
         valid <= 1'b1;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

   // Delivery counter: clear has priority, otherwise count handshakes up to the ceiling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= '0;
      end else if (drain && (cnt != CNT_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 stream router: steers each accepted word into the holding
// register of the channel named by in_dest.
module stream_demux_1to4
   import stream_demux_1to4_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   stream_demux_1to4_if.slave      bus,
   input  logic                    cnt_clr,
   output logic [NUM_CH*CNT_W-1:0] out_cnt
);

   logic              accept;
   logic [NUM_CH-1:0] load;

   // Only the addressed channel can stall the input; it is free when empty or draining.
   assign bus.in_ready = rst_n & (~bus.out_valid[bus.in_dest] | bus.out_ready[bus.in_dest]);
   assign accept       = bus.in_valid & bus.in_ready;
   assign load         = accept ? dest_onehot(bus.in_dest) : '0;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      demux_channel_reg #(
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[k]),
         .load_data (bus.in_data),
         .ready     (bus.out_ready[k]),
         .cnt_clr   (cnt_clr),
         .data      (bus.out_data[k*DATA_W +: DATA_W]),
         .valid     (bus.out_valid[k]),
         .cnt       (out_cnt[k*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Bench for the 1-to-4 stream router: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural channel model.
module tb_stream_demux_1to4;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic             clk     = 1'b0;
   logic             rst_n   = 1'b0;
   logic             cnt_clr = 1'b0;
   logic [4*CNT_W-1:0] out_cnt;

   stream_demux_1to4_if #(.DATA_W(DATA_W)) bus ();

   stream_demux_1to4 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .cnt_clr (cnt_clr),
      .out_cnt (out_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   // Behavioural model: per-channel held word, full flag and delivery count.
   int m_v [4] = '{default: 0};
   int m_d [4] = '{default: 0};
   int m_c [4] = '{default: 0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_ready();
      return rst_n && (m_v[bus.in_dest] == 0 || bus.out_ready[bus.in_dest]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            m_v[k] <= 0;
            m_d[k] <= 0;
            m_c[k] <= 0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (bus.in_valid && model_ready() && int'(bus.in_dest) == k) begin
               m_v[k] <= 1;
               m_d[k] <= int'(bus.in_data);
            end else if (m_v[k] != 0 && bus.out_ready[k]) begin
               m_v[k] <= 0;
            end
            if (cnt_clr)
               m_c[k] <= 0;
            else if (m_v[k] != 0 && bus.out_ready[k])
               m_c[k] <= (m_c[k] + 1 > CMAX) ? CMAX : m_c[k] + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("in_ready", 32'(bus.in_ready), 32'(model_ready()));
         for (int k = 0; k < 4; k++) begin
            check($sformatf("valid[%0d]", k), 32'(bus.out_valid[k]), 32'(m_v[k]));
            check($sformatf("data[%0d]", k), 32'(bus.out_data[k*DATA_W +: DATA_W]), 32'(m_d[k]));
            check($sformatf("cnt[%0d]", k), 32'(out_cnt[k*CNT_W +: CNT_W]), 32'(m_c[k]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_in(input logic v, input logic [1:0] d, input logic [7:0] data);
      bus.in_valid = v;
      bus.in_dest  = d;
      bus.in_data  = data;
   endtask

   initial begin
      set_in(1'b0, 2'd0, 8'h00);
      bus.out_ready = 4'b0000;
      cmp_en = 1'b1;

      // Reset then idle
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("idle_ready", 32'(bus.in_ready), 32'd1);
      check("idle_valid", 32'(bus.out_valid), 32'd0);
      check("idle_cnt", 32'(out_cnt), 32'd0);
      step();

      // Single routing
      bus.out_ready = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 2'(i), 8'(8'hA0 + i));
         step();
         check($sformatf("route_data%0d", i), 32'(bus.out_data[i*DATA_W +: DATA_W]), 32'(8'hA0 + i));
         check($sformatf("route_valid%0d", i), 32'(bus.out_valid[i]), 32'd1);
      end
      set_in(1'b0, 2'd0, 8'h00);
      step();
      check("route_cnt", 32'(out_cnt), 32'h1111);
      check("route_empty", 32'(bus.out_valid), 32'd0);

      // Backpressure isolation
      bus.out_ready = 4'b1011;
      set_in(1'b1, 2'd2, 8'h55);
      step();
      check("bp_ch2_data", 32'(bus.out_data[2*DATA_W +: DATA_W]), 32'h55);
      set_in(1'b1, 2'd2, 8'h66);
      #1 check("bp_stall_ready", 32'(bus.in_ready), 32'd0);
      step();
      check("bp_ch2_held", 32'(bus.out_data[2*DATA_W +: DATA_W]), 32'h55);
      set_in(1'b1, 2'd0, 8'h77);
      #1 check("bp_other_ready", 32'(bus.in_ready), 32'd1);
      step();
      check("bp_ch0_data", 32'(bus.out_data[0 +: DATA_W]), 32'h77);
      check("bp_valid", 32'(bus.out_valid), 32'b0101);
      set_in(1'b1, 2'd2, 8'h66);
      bus.out_ready = 4'b1111;
      #1 check("bp_release_ready", 32'(bus.in_ready), 32'd1);
      step();
      check("bp_ch2_new", 32'(bus.out_data[2*DATA_W +: DATA_W]), 32'h66);
      set_in(1'b0, 2'd0, 8'h00);
      step();

      // Simultaneous drain and load
      bus.out_ready = 4'b1101;
      set_in(1'b1, 2'd1, 8'h10);
      step();
      bus.out_ready = 4'b1111;
      set_in(1'b1, 2'd1, 8'h11);
      step();
      check("dl_valid1", 32'(bus.out_valid[1]), 32'd1);
      check("dl_data1", 32'(bus.out_data[1*DATA_W +: DATA_W]), 32'h11);
      check("dl_cnt1", 32'(out_cnt[1*CNT_W +: CNT_W]), 32'd2);
      set_in(1'b0, 2'd0, 8'h00);
      step();

      // Counter saturation and clear
      for (int i = 0; i < 20; i++) begin
         set_in(1'b1, 2'd3, 8'(i));
         step();
      end
      set_in(1'b0, 2'd0, 8'h00);
      step();
      check("sat_cnt3", 32'(out_cnt[3*CNT_W +: CNT_W]), 32'd15);
      set_in(1'b1, 2'd3, 8'hC3);
      step();
      set_in(1'b0, 2'd0, 8'h00);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      check("clr_cnt", 32'(out_cnt), 32'd0);
      check("clr_valid3", 32'(bus.out_valid[3]), 32'd0);
      check("clr_data3", 32'(bus.out_data[3*DATA_W +: DATA_W]), 32'hC3);

      // Reset mid-operation
      bus.out_ready = 4'b0000;
      set_in(1'b1, 2'd0, 8'h81);
      step();
      set_in(1'b1, 2'd2, 8'h82);
      step();
      set_in(1'b0, 2'd0, 8'h00);
      check("mr_full", 32'(bus.out_valid), 32'b0101);
      #1 rst_n = 1'b0;
      #1;
      check("mr_valid_drop", 32'(bus.out_valid), 32'd0);
      check("mr_ready_low", 32'(bus.in_ready), 32'd0);
      check("mr_data_clr", 32'(bus.out_data), 32'd0);
      step();
      rst_n = 1'b1;
      set_in(1'b1, 2'd0, 8'h99);
      #1 check("mr_first_ready", 32'(bus.in_ready), 32'd1);
      step();
      check("mr_first_valid", 32'(bus.out_valid[0]), 32'd1);
      check("mr_first_data", 32'(bus.out_data[0 +: DATA_W]), 32'h99);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         bus.out_ready = 4'($urandom);
         set_in($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom));
         cnt_clr = ($urandom_range(0, 63) == 0);
         rst_n   = ($urandom_range(0, 499) != 0);
         step();
      end
      rst_n   = 1'b1;
      cnt_clr = 1'b0;
      set_in(1'b0, 2'd0, 8'h00);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_demux_1to4.md
Name: stream_demux_1to4

Overview:
- Registered 1-to-4 stream router built around the 2-to-4 demux function.
- Accepts one data word plus a 2-bit destination over a valid/ready handshake and steers it into one of four output holding registers, each with its own valid/ready handshake.
- Sits directly downstream of the data source and feeds four consumer channels.
- Keeps a saturating per-channel delivery count for debug.

Parameters:
- DATA_W, 8, width of data word
- CNT_W, 8, width of each per-channel delivery counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  DATA_W  input data word
- in_dest  input  2  destination channel 0..3
- in_valid  input  1  input word and destination are valid
- in_ready  output  1  block can accept the input this cycle
- out_data  output  4*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- out_valid  output  4  per-channel valid
- out_ready  input  4  per-channel ready from the consumer
- cnt_clr  input  1  synchronous clear of all counters
- out_cnt  output  4*CNT_W  channel k delivery count at [k*CNT_W +: CNT_W]

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - out_valid=0, out_data=0, out_cnt=0.
  - in_ready reads 0 while rst_n=0.
- Each channel k has a one-entry holding register (data plus valid flag).
- in_ready is combinational: in_ready = rst_n & (!out_valid[in_dest] | out_ready[in_dest]).
  - It depends only on the addressed channel.
  - Backpressure on other channels never stalls the input.
- Input handshake: in_valid & in_ready at a clock edge.
  - That edge loads in_data into channel in_dest and sets out_valid[in_dest]=1.
  - Latency is one cycle: data is visible on the output the cycle after acceptance.
- Output handshake: out_valid[k] & out_ready[k] at an edge.
  - Clears out_valid[k] unless a new word is loaded into k on the same edge.
  - When a load happens on the same edge, out_valid[k] stays 1 and the new data replaces the old. This gives full throughput of one word per cycle per channel.
- out_data[k] holds its last value while out_valid[k]=0. It is only updated on a load.
- No drop or overwrite: a word is never loaded into a full channel that is not draining, because in_ready is 0 in that case.
- in_valid=0 means no state change from the input side, regardless of in_dest and in_data.
- Counters:
  - out_cnt[k] increments on each output handshake of channel k.
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 zeroes all counters on the next edge. If cnt_clr coincides with a handshake, the counter goes to 0 (clear wins). cnt_clr does not affect data or valid.
- Several channels may complete output handshakes on the same edge. All are independent.
- Reset mid-operation: all held words are discarded and all valids drop immediately. After release, the first accept happens on the first edge with rst_n=1.

Decomposition:
- Shared package holds:
  - NUM_CH=4
  - DEST_W=2
  - default DATA_W and CNT_W constants
  - a function computing the one-hot channel enable from dest (the 2-to-4 decode).
- One natural sub-module, demux_channel_reg: the one-entry holding register, valid flag and saturating counter for a single channel. Instantiate it four times, with a top-level decode of in_dest to a load strobe.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 for 3 cycles, then release with in_valid=0.
  - Response: out_valid=4'b0000, out_cnt all 0, in_ready=1 after release.
- Single routing:
  - Stimulus: out_ready=4'b1111; send 0xA0,0xA1,0xA2,0xA3 with dest 0,1,2,3 on consecutive cycles.
  - Response: each word appears on its channel exactly one cycle after acceptance; out_cnt = 1,1,1,1.
- Backpressure isolation:
  - Stimulus: out_ready[2]=0; send 0x55 to dest 2, then 0x66 to dest 2, then 0x77 to dest 0.
  - Response: 0x55 held on ch2; in_ready=0 for the second word; 0x77 is accepted and appears on ch0 while ch2 is still stalled; 0x66 is accepted when out_ready[2] rises.
- Simultaneous drain and load:
  - Stimulus: ch1 holds 0x10 with out_ready[1]=1; send 0x11 to dest 1 on the same cycle.
  - Response: out_valid[1] stays 1, out_data ch1 becomes 0x11 the next cycle, out_cnt[1] increments by 1.
- Counter saturation and clear:
  - Stimulus: CNT_W=4, push 20 words to ch3 with out_ready[3]=1.
  - Response: out_cnt[3]=15. Then cnt_clr=1 coincident with a handshake gives out_cnt[3]=0.
- Reset mid-operation:
  - Stimulus: with ch0 and ch2 full and stalled, assert rst_n=0 between edges.
  - Response: out_valid drops to 0 immediately (before the next edge); after release the next word sent to dest 0 is accepted on the first edge.
